// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback stage: result select, load extension, registered write port, bypass history
// Entry 0 of the history is the register-file write port itself; older entries serve decode-stage bypass.
module writeback_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int HIST_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidM,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic [REG_ADDR_W-1:0] RDM,
  input  logic                  RegWriteEnM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            LoadTypeM,
  input  logic [1:0]            ByteOffM,
  input  logic [XLEN-1:0]       ALU_ResultW,
  input  logic [31:0]           ReadDataW,
  input  logic [XLEN-1:0]       PCPlus4W,
  input  logic [XLEN-1:0]       ImmW,
  output logic [REG_ADDR_W-1:0] RdD,
  output logic [XLEN-1:0]       ResultD,
  output logic                  RegWriteEnD,
  input  logic [REG_ADDR_W-1:0] Rs1Q,
  input  logic [REG_ADDR_W-1:0] Rs2Q,
  output logic                  Hit1,
  output logic                  Hit2,
  output logic [XLEN-1:0]       Data1,
  output logic [XLEN-1:0]       Data2
);

  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [XLEN-1:0] loadExt;
  logic [XLEN-1:0] selResult;
  logic            commit;

  logic                  histValid [HIST_DEPTH];
  logic [REG_ADDR_W-1:0] histRd    [HIST_DEPTH];
  logic [XLEN-1:0]       histData  [HIST_DEPTH];

  always_comb begin
    case (ByteOffM)
      2'd0:    loadByte = ReadDataW[7:0];
      2'd1:    loadByte = ReadDataW[15:8];
      2'd2:    loadByte = ReadDataW[23:16];
      default: loadByte = ReadDataW[31:24];
    endcase
    // Halfword loads ignore the low offset bit; misaligned halves are not split.
    loadHalf = ByteOffM[1] ? ReadDataW[31:16] : ReadDataW[15:0];
  end

  always_comb begin
    case (LoadTypeM)
      3'b000:  loadExt = XLEN'($signed(loadByte));
      3'b001:  loadExt = XLEN'($signed(loadHalf));
      3'b100:  loadExt = XLEN'(loadByte);
      3'b101:  loadExt = XLEN'(loadHalf);
      default: loadExt = XLEN'($signed(ReadDataW));
    endcase
  end

  always_comb begin
    case (ResultSrcM)
      2'b00:   selResult = ALU_ResultW;
      2'b01:   selResult = loadExt;
      2'b10:   selResult = PCPlus4W;
      default: selResult = ImmW;
    endcase
  end

  assign commit = ValidM & ~FlushW & RegWriteEnM & (RDM != '0);

  // A flush advances the history even under stall; commit is already low then.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < HIST_DEPTH; k++) begin
        histValid[k] <= 1'b0;
        histRd[k]    <= '0;
        histData[k]  <= '0;
      end
    end else if (FlushW || !StallW) begin
      for (int k = HIST_DEPTH - 1; k > 0; k--) begin
        histValid[k] <= histValid[k-1];
        histRd[k]    <= histRd[k-1];
        histData[k]  <= histData[k-1];
      end
      histValid[0] <= commit;
      histRd[0]    <= commit ? RDM : '0;
      histData[0]  <= commit ? selResult : '0;
    end
  end

  assign RegWriteEnD = histValid[0];
  assign RdD         = histRd[0];
  assign ResultD     = histData[0];

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    Hit1  = 1'b0;
    Hit2  = 1'b0;
    Data1 = '0;
    Data2 = '0;
    for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
      if (histValid[k] && (histRd[k] == Rs1Q) && (Rs1Q != '0)) begin
        Hit1  = 1'b1;
        Data1 = histData[k];
      end
      if (histValid[k] && (histRd[k] == Rs2Q) && (Rs2Q != '0)) begin
        Hit2  = 1'b1;
        Data2 = histData[k];
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed and randomized bench for writeback_unit
// Reference model keeps the history as plain arrays updated from the architectural rules.
module tb_writeback_unit;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int HD   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            ValidM, StallW, FlushW, RegWriteEnM;
  logic [RW-1:0]   RDM, Rs1Q, Rs2Q, RdD;
  logic [1:0]      ResultSrcM, ByteOffM;
  logic [2:0]      LoadTypeM;
  logic [XLEN-1:0] ALU_ResultW, PCPlus4W, ImmW, ResultD, Data1, Data2;
  logic [31:0]     ReadDataW;
  logic            RegWriteEnD, Hit1, Hit2;

  writeback_unit #(.XLEN(XLEN), .REG_ADDR_W(RW), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .StallW(StallW), .FlushW(FlushW),
    .RDM(RDM), .RegWriteEnM(RegWriteEnM), .ResultSrcM(ResultSrcM),
    .LoadTypeM(LoadTypeM), .ByteOffM(ByteOffM), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .ImmW(ImmW),
    .RdD(RdD), .ResultD(ResultD), .RegWriteEnD(RegWriteEnD),
    .Rs1Q(Rs1Q), .Rs2Q(Rs2Q), .Hit1(Hit1), .Hit2(Hit2), .Data1(Data1), .Data2(Data2)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  logic            mValid [HD];
  logic [RW-1:0]   mRd    [HD];
  logic [XLEN-1:0] mData  [HD];

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [2:0] t, input logic [1:0] off,
                                          input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (t)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] refResult();
    case (ResultSrcM)
      2'd0:    return ALU_ResultW;
      2'd1:    return refLoad(LoadTypeM, ByteOffM, ReadDataW);
      2'd2:    return PCPlus4W;
      default: return ImmW;
    endcase
  endfunction

  task automatic modelEdge();
    bit writes;
    writes = ValidM && !FlushW && RegWriteEnM && (RDM != 0);
    if (rst) begin
      for (int k = 0; k < HD; k++) begin
        mValid[k] = 1'b0; mRd[k] = '0; mData[k] = '0;
      end
    end else if (FlushW || !StallW) begin
      for (int k = HD - 1; k > 0; k--) begin
        mValid[k] = mValid[k-1]; mRd[k] = mRd[k-1]; mData[k] = mData[k-1];
      end
      mValid[0] = writes;
      mRd[0]    = writes ? RDM : '0;
      mData[0]  = writes ? refResult() : '0;
    end
  endtask

  task automatic modelQuery(input logic [RW-1:0] rs, output logic hit, output logic [XLEN-1:0] data);
    hit = 1'b0;
    data = '0;
    if (rs != 0) begin
      for (int k = 0; k < HD; k++) begin
        if (mValid[k] && mRd[k] == rs) begin
          hit = 1'b1;
          data = mData[k];
          break;
        end
      end
    end
  endtask

  task automatic checkAll(input string phase);
    logic            h;
    logic [XLEN-1:0] d;
    checkEq({phase, ".RdD"}, 64'(RdD), 64'(mRd[0]));
    checkEq({phase, ".ResultD"}, 64'(ResultD), 64'(mData[0]));
    checkEq({phase, ".RegWriteEnD"}, 64'(RegWriteEnD), 64'(mValid[0]));
    modelQuery(Rs1Q, h, d);
    checkEq({phase, ".Hit1"}, 64'(Hit1), 64'(h));
    checkEq({phase, ".Data1"}, 64'(Data1), 64'(d));
    modelQuery(Rs2Q, h, d);
    checkEq({phase, ".Hit2"}, 64'(Hit2), 64'(h));
    checkEq({phase, ".Data2"}, 64'(Data2), 64'(d));
  endtask

  task automatic tick(input string phase);
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(phase);
  endtask

  task automatic setInstr(input logic [RW-1:0] rd, input logic [1:0] src, input logic [XLEN-1:0] val);
    ValidM = 1'b1; RegWriteEnM = 1'b1; RDM = rd; ResultSrcM = src;
    ALU_ResultW = val; PCPlus4W = val; ImmW = val;
  endtask

  logic [2:0]  ldType [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b111};
  logic [1:0]  ldOff  [5] = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd0};
  logic [31:0] ldExp  [5] = '{32'hFFFF_FFBB, 32'h0000_0099, 32'hFFFF_8899, 32'h0000_8899, 32'h8899_AABB};

  initial begin
    rst = 1'b1; ValidM = 0; StallW = 0; FlushW = 0; RegWriteEnM = 0;
    RDM = 0; Rs1Q = 0; Rs2Q = 0; ResultSrcM = 0; LoadTypeM = 0; ByteOffM = 0;
    ALU_ResultW = 0; PCPlus4W = 0; ImmW = 0; ReadDataW = 0;
    for (int k = 0; k < HD; k++) begin
      mValid[k] = 1'b0; mRd[k] = '0; mData[k] = '0;
    end
    #2;
    tick("reset");
    checkEq("reset.RegWriteEnD0", 64'(RegWriteEnD), 64'd0);
    rst = 1'b0;

    setInstr(5'd10, 2'b00, 32'hAABB_CCDD);
    tick("alu");
    checkEq("alu.RdD10", 64'(RdD), 64'd10);
    checkEq("alu.Result", 64'(ResultD), 64'hAABB_CCDD);
    checkEq("alu.WriteEn", 64'(RegWriteEnD), 64'd1);

    ResultSrcM = 2'b01; ReadDataW = 32'h8899_AABB;
    for (int i = 0; i < 5; i++) begin
      LoadTypeM = ldType[i]; ByteOffM = ldOff[i];
      tick($sformatf("load%0d", i));
      checkEq($sformatf("load%0d.const", i), 64'(ResultD), 64'(ldExp[i]));
    end

    setInstr(5'd1, 2'b10, 32'h5566_7788);
    tick("jal");
    checkEq("jal.Result", 64'(ResultD), 64'h5566_7788);
    RDM = 5'd0;
    tick("jalx0");
    checkEq("jalx0.WriteEn", 64'(RegWriteEnD), 64'd0);
    checkEq("jalx0.Result", 64'(ResultD), 64'd0);

    setInstr(5'd3, 2'b00, 32'h0000_1234);
    tick("prestall");
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setInstr(5'(i + 4), 2'b00, $urandom);
      tick($sformatf("stall%0d", i));
      checkEq($sformatf("stall%0d.const", i), 64'(ResultD), 64'h1234);
    end
    FlushW = 1'b1;
    tick("flushstall");
    checkEq("flushstall.WriteEn", 64'(RegWriteEnD), 64'd0);
    StallW = 1'b0; FlushW = 1'b0;

    Rs1Q = 5'd5; Rs2Q = 5'd3;
    setInstr(5'd5, 2'b00, 32'h11);
    tick("x5a");
    setInstr(5'd5, 2'b00, 32'h22);
    tick("x5b");
    checkEq("hist.Hit1", 64'(Hit1), 64'd1);
    checkEq("hist.Data1", 64'(Data1), 64'h22);
    ValidM = 1'b0;
    tick("bubble0");
    tick("bubble1");
    checkEq("aged.Hit1", 64'(Hit1), 64'd0);
    checkEq("aged.Data1", 64'(Data1), 64'd0);

    setInstr(5'd7, 2'b11, 32'h77);
    tick("fill0");
    setInstr(5'd8, 2'b11, 32'h88);
    tick("fill1");
    Rs1Q = 5'd8; Rs2Q = 5'd7;
    rst = 1'b1; StallW = 1'b1;
    tick("midreset");
    checkEq("midreset.Hit1", 64'(Hit1), 64'd0);
    checkEq("midreset.Hit2", 64'(Hit2), 64'd0);
    checkEq("midreset.RdD", 64'(RdD), 64'd0);
    rst = 1'b0; StallW = 1'b0;

    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(99) < 2);
      StallW      = ($urandom_range(99) < 20);
      FlushW      = ($urandom_range(99) < 10);
      ValidM      = ($urandom_range(99) < 80);
      RegWriteEnM = ($urandom_range(99) < 85);
      RDM         = 5'($urandom_range(7));
      Rs1Q        = 5'($urandom_range(7));
      Rs2Q        = 5'($urandom_range(7));
      ResultSrcM  = 2'($urandom);
      LoadTypeM   = 3'($urandom);
      ByteOffM    = 2'($urandom);
      ALU_ResultW = $urandom;
      ReadDataW   = $urandom;
      PCPlus4W    = $urandom;
      ImmW        = $urandom;
      tick($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
